mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32: address width.
REQ-002 The block SHALL have parameter DATA_W, default 32: data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 16: maximum number of busy cycles waited for an ack.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: i_clk  in  1  clock, rising edge; i_reset  in  1  synchronous active-high reset.
REQ-005 The block SHALL have the instruction-fetch request inputs: i_if_req  in  1  fetch request; i_if_addr  in  ADDR_W  fetch address; i_if_flush  in  1  cancel the current or pending fetch.
REQ-006 The block SHALL have the data-memory request inputs: i_dm_req  in  1  data request; i_dm_we  in  1  write enable; i_dm_addr  in  ADDR_W  address; i_dm_wdata  in  DATA_W  write data; i_dm_bmask  in  4  byte mask.
REQ-007 The block SHALL have the requester outputs: o_if_valid  out  1  fetch done; o_if_rdata  out  DATA_W  fetched word; o_dm_valid  out  1  data access done; o_dm_rdata  out  DATA_W  load data.
REQ-008 The block SHALL have the pipeline-control outputs: o_stall_if  out  1  hold PC and IF/ID; o_stall_dm  out  1  hold the pipeline from DM back; o_err  out  1  timeout pulse.
REQ-009 The block SHALL have the memory-side ports: o_mem_req  out  1; o_mem_we  out  1; o_mem_addr  out  ADDR_W; o_mem_wdata  out  DATA_W; o_mem_bmask  out  4; i_mem_ack  in  1  one-cycle completion pulse; i_mem_rdata  in  DATA_W  valid when i_mem_ack is high.

Function
REQ-010 The state machine SHALL have three states, IDLE, BUSY_IF and BUSY_DM, and SHALL be in IDLE after reset.
REQ-011 In IDLE with i_dm_req=1, the next state SHALL be BUSY_DM, regardless of i_if_req; a DM request has fixed priority over IF.
REQ-012 In IDLE with i_dm_req=0, i_if_req=1 and i_if_flush=0, the next state SHALL be BUSY_IF.
REQ-013 On entry to a BUSY state, the o_mem_* outputs SHALL be loaded from the winning requester.
- These outputs are registered and stay stable until the transaction ends.
- For IF, o_mem_we=0 and o_mem_bmask=4'hF.
REQ-014 o_mem_req SHALL be 1 exactly while the state is BUSY_IF or BUSY_DM.
REQ-015 In a BUSY state with i_mem_ack=1, the block SHALL:
- return to IDLE;
- register i_mem_rdata into the matching o_*_rdata;
- pulse the matching o_*_valid for exactly one cycle.
REQ-016 The minimum latency SHALL be 2 cycles: request sampled in cycle N, o_mem_req in N+1, ack in N+1, valid in N+2.
REQ-017 A new arbitration SHALL be possible in the cycle o_*_valid is high; a request still asserted then is treated as a new transaction.
REQ-018 o_stall_if SHALL equal i_if_req and not o_if_valid (combinational), and SHALL be 0 if i_if_flush=1.
REQ-019 o_stall_dm SHALL equal i_dm_req and not o_dm_valid (combinational).
REQ-020 If i_if_flush=1 in BUSY_IF, the block SHALL set a discard flag.
- The transaction completes on the bus.
- o_if_valid stays 0 and o_if_rdata is unchanged at completion.
- The flag clears on return to IDLE.
REQ-021 i_mem_ack received in IDLE SHALL be ignored.
REQ-022 A busy counter SHALL clear on BUSY entry and increment each BUSY cycle without ack.
REQ-023 When the busy counter reaches TIMEOUT_CYC-1 without an ack, on the next edge the block SHALL:
- return to IDLE with o_mem_req=0;
- pulse o_err for one cycle;
- pulse the owner's o_*_valid with rdata=0 (IF valid suppressed if the discard flag is set).
REQ-024 Ack and timeout in the same cycle SHALL be treated as an ack: data captured, o_err stays 0.
REQ-025 Request inputs SHALL be ignored while the block is BUSY; they are sampled again only in IDLE.

Reset
REQ-026 While i_reset=1 at a clock edge, the block SHALL go to IDLE, even mid-transaction.
- o_mem_req, o_mem_we, o_if_valid, o_dm_valid and o_err SHALL be 0.
- o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata and the busy counter SHALL be 0.
- o_mem_bmask SHALL be 0, and the discard flag SHALL be cleared.
REQ-027 Any ack that arrives after reset for a transaction abandoned by reset SHALL be ignored, per REQ-021.

Structure
REQ-028 The state enum (IDLE, BUSY_IF, BUSY_DM) and the default width constants SHALL live in package mem_arb_pkg.
REQ-029 The busy/timeout counter SHALL be a sub-module named mem_arb_timer (inputs clear and enable; output expired); all other logic SHALL stay in mem_port_arbiter.

Verification
REQ-030 Single IF fetch:
- stimulus: i_if_req=1, addr 0x100; ack 1 cycle after o_mem_req, rdata 0x00A00093;
- required: o_if_valid in cycle N+2 with o_if_rdata=0x00A00093, and o_stall_if=1 until then.
REQ-031 Simultaneous requests:
- stimulus: IF addr 0x104 and DM load addr 0x2000 in the same cycle;
- required: DM is issued first (o_mem_addr=0x2000, we=0), then IF 0x104 is issued in the cycle o_dm_valid is high.
REQ-032 DM store:
- stimulus: we=1, addr 0x2004, wdata 0xDEADBEEF, bmask 4'b0011, ack delayed 3 cycles;
- required: o_mem_* are held stable for all 4 busy cycles, and o_dm_valid pulses once.
REQ-033 Flush during fetch:
- stimulus: i_if_flush=1 in the second BUSY_IF cycle, then ack with 0x12345678;
- required: o_if_valid is never 1 and o_if_rdata keeps its prior value.
REQ-034 Timeout:
- stimulus: DM load with no ack;
- required: after 16 busy cycles o_mem_req falls, o_err=1 and o_dm_valid=1 with rdata 0 for one cycle, and the block is then IDLE.
REQ-035 Reset mid-transaction and stray ack:
- stimulus: i_reset in the third BUSY_DM cycle, then a stray ack 2 cycles later;
- required: all outputs are 0 after the edge, and the stray ack produces no valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the memory port arbiter.
package mem_arb_pkg;

   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_DATA_W      = 32;
   localparam int DEF_TIMEOUT_CYC = 16;
   localparam int BMASK_W         = 4;

   // Fetches always read a full word.
   localparam logic [BMASK_W-1:0] IF_BMASK = 4'hF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_e;

   function automatic logic is_busy(input arb_state_e s);
      return (s != IDLE);
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter: held at zero while cleared, counts enabled cycles,
// flags expiry once TIMEOUT_CYC-1 un-acked busy cycles have elapsed.
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_count;

   // Count up while enabled; saturate at the terminal value.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_count <= '0;
      end else if (i_enable && !o_expired) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expired = (r_count == TERM_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by instruction fetch and data memory.
// DM has fixed priority; one transaction outstanding at a time, with
// a busy-cycle timeout and a flush that discards an in-flight fetch.
//
//   state   | meaning
//   --------+-------------------------------------------
//   IDLE    | no transaction, arbitrating requests
//   BUSY_IF | fetch on the bus, waiting for ack
//   BUSY_DM | data access on the bus, waiting for ack
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_if_req,
   input  logic [ADDR_W-1:0]    i_if_addr,
   input  logic                 i_if_flush,
   input  logic                 i_dm_req,
   input  logic                 i_dm_we,
   input  logic [ADDR_W-1:0]    i_dm_addr,
   input  logic [DATA_W-1:0]    i_dm_wdata,
   input  logic [BMASK_W-1:0]   i_dm_bmask,
   output logic                 o_if_valid,
   output logic [DATA_W-1:0]    o_if_rdata,
   output logic                 o_dm_valid,
   output logic [DATA_W-1:0]    o_dm_rdata,
   output logic                 o_stall_if,
   output logic                 o_stall_dm,
   output logic                 o_err,
   output logic                 o_mem_req,
   output logic                 o_mem_we,
   output logic [ADDR_W-1:0]    o_mem_addr,
   output logic [DATA_W-1:0]    o_mem_wdata,
   output logic [BMASK_W-1:0]   o_mem_bmask,
   input  logic                 i_mem_ack,
   input  logic [DATA_W-1:0]    i_mem_rdata
);

   arb_state_e          r_state;
   arb_state_e          w_next_state;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic [BMASK_W-1:0]  r_mem_bmask;
   logic                r_if_valid;
   logic [DATA_W-1:0]   r_if_rdata;
   logic                r_dm_valid;
   logic [DATA_W-1:0]   r_dm_rdata;
   logic                r_err;
   logic                r_discard;

   logic                w_busy;
   logic                w_ack;
   logic                w_expired;
   logic                w_timeout;
   logic                w_done;
   logic                w_discard;
   logic                w_issue_dm;
   logic                w_issue_if;

   assign w_busy     = is_busy(r_state);
   assign w_ack      = w_busy & i_mem_ack;
   // An ack in the expiry cycle wins over the timeout.
   assign w_timeout  = w_busy & w_expired & ~i_mem_ack;
   assign w_done     = w_ack | w_timeout;
   // A flush in the completing cycle also cancels the fetch.
   assign w_discard  = r_discard | i_if_flush;
   assign w_issue_dm = (r_state == IDLE) & i_dm_req;
   assign w_issue_if = (r_state == IDLE) & ~i_dm_req & i_if_req & ~i_if_flush;

   mem_arb_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (~w_busy),
      .i_enable  (w_busy & ~i_mem_ack),
      .o_expired (w_expired)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: arbitrate in IDLE, leave BUSY on ack or timeout.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_issue_dm) begin
               w_next_state = BUSY_DM;
            end else if (w_issue_if) begin
               w_next_state = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (w_done) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Bus fields latched at issue, completion data/valid/err pulses, discard flag.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_bmask <= '0;
         r_if_valid  <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_valid  <= 1'b0;
         r_dm_rdata  <= '0;
         r_err       <= 1'b0;
         r_discard   <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;
         r_err      <= 1'b0;
         case (r_state)
            IDLE: begin
               r_discard <= 1'b0;
               if (w_issue_dm) begin
                  r_mem_we    <= i_dm_we;
                  r_mem_addr  <= i_dm_addr;
                  r_mem_wdata <= i_dm_wdata;
                  r_mem_bmask <= i_dm_bmask;
               end else if (w_issue_if) begin
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= i_if_addr;
                  r_mem_wdata <= '0;
                  r_mem_bmask <= IF_BMASK;
               end
            end
            BUSY_IF: begin
               if (i_if_flush) begin
                  r_discard <= 1'b1;
               end
               if (w_done) begin
                  r_err <= w_timeout;
                  if (!w_discard) begin
                     r_if_valid <= 1'b1;
                     r_if_rdata <= w_ack ? i_mem_rdata : '0;
                  end
               end
            end
            BUSY_DM: begin
               if (w_done) begin
                  r_err      <= w_timeout;
                  r_dm_valid <= 1'b1;
                  r_dm_rdata <= w_ack ? i_mem_rdata : '0;
               end
            end
            default: r_discard <= 1'b0;
         endcase
      end
   end

   assign o_mem_req   = w_busy;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_mem_bmask = r_mem_bmask;
   assign o_if_valid  = r_if_valid;
   assign o_if_rdata  = r_if_rdata;
   assign o_dm_valid  = r_dm_valid;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_err       = r_err;
   assign o_stall_if  = i_if_req & ~r_if_valid & ~i_if_flush;
   assign o_stall_dm  = i_dm_req & ~r_dm_valid;

endmodule
